// File: rtl/controlador_alarmas_pkg.sv
// Shared types and default timing for the alarm actuator stage.
// State encoding is reused by display/status blocks.
package controlador_alarmas_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    LEVE     = 2'd1,
    GRAVE    = 2'd2,
    SILENCIO = 2'd3
  } estado_t;

  localparam int TICK_DIV_DEF    = 50000;
  localparam int GRAVE_ON_DEF    = 250;
  localparam int GRAVE_OFF_DEF   = 250;
  localparam int LEVE_ON_DEF     = 100;
  localparam int LEVE_OFF_DEF    = 900;
  localparam int SILENCIO_MS_DEF = 30000;
  localparam int VENT_MIN_MS_DEF = 5000;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controlador_alarmas_generador_tick.sv
// Free-running prescaler producing a one-clk tick
// every TICK_DIV clocks; shared by timed blocks.
module generador_tick
  import controlador_alarmas_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = cnt_width(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Tick on the last count, then wrap to zero.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/controlador_alarmas.sv
// Alarm actuator: buzzer pattern, alert LED,
// ventilation motor hold and acknowledge/silence.
module controlador_alarmas
  import controlador_alarmas_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int GRAVE_ON    = GRAVE_ON_DEF,
  parameter int GRAVE_OFF   = GRAVE_OFF_DEF,
  parameter int LEVE_ON     = LEVE_ON_DEF,
  parameter int LEVE_OFF    = LEVE_OFF_DEF,
  parameter int SILENCIO_MS = SILENCIO_MS_DEF,
  parameter int VENT_MIN_MS = VENT_MIN_MS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_grave,
  input  logic       alarm_leve,
  input  logic       ventilacion,
  input  logic       iluminacion,
  input  logic       reconocer,
  output logic       buzzer,
  output logic       led_alerta,
  output logic       vent_motor,
  output logic [1:0] estado
);

  localparam int PMAX = max_int(max_int(GRAVE_ON, GRAVE_OFF),
                                max_int(LEVE_ON, LEVE_OFF));
  localparam int PW = cnt_width(PMAX);
  localparam int SW = cnt_width(SILENCIO_MS + 1);
  localparam int VW = cnt_width(VENT_MIN_MS + 1);

  localparam logic [PW-1:0] G_ON_L  = PW'(GRAVE_ON - 1);
  localparam logic [PW-1:0] G_OFF_L = PW'(GRAVE_OFF - 1);
  localparam logic [PW-1:0] L_ON_L  = PW'(LEVE_ON - 1);
  localparam logic [PW-1:0] L_OFF_L = PW'(LEVE_OFF - 1);
  localparam logic [SW-1:0] SIL_LD  = SW'(SILENCIO_MS);
  localparam logic [VW-1:0] VENT_LD = VW'(VENT_MIN_MS);

  logic          tick;
  logic [3:0]    s1_q, s2_q;
  logic          g_s, l_s, v_s, i_s;
  estado_t       est_q, est_d;
  logic          fase_q, fase_d;
  logic [PW-1:0] pat_q, pat_d, lim;
  logic [SW-1:0] sil_q, sil_d;
  logic [VW-1:0] vent_q, vent_d;
  logic          mot_q, mot_d;
  logic          buz_q, buz_d;
  logic          led_q, led_d;
  logic          activo, entra;

  generador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign g_s = s2_q[3];
  assign l_s = s2_q[2];
  assign v_s = s2_q[1];
  assign i_s = s2_q[0];

  // Next state with GRAVE overriding everything; silence window timing.
  always_comb begin
    est_d = est_q;
    sil_d = sil_q;
    if (g_s) begin
      est_d = GRAVE;
    end else begin
      unique case (est_q)
        REPOSO: if (l_s) est_d = LEVE;
        LEVE: begin
          if (reconocer) begin
            est_d = SILENCIO;
            sil_d = SIL_LD;
          end else if (!l_s) begin
            est_d = REPOSO;
          end
        end
        GRAVE: est_d = l_s ? LEVE : REPOSO;
        SILENCIO: begin
          if (sil_q == '0)  est_d = l_s ? LEVE : REPOSO;
          else if (tick)    sil_d = sil_q - SW'(1);
        end
      endcase
    end
  end

  // Beep phase; any entry into an audible state restarts at ON.
  always_comb begin
    activo = (est_d == LEVE) || (est_d == GRAVE);
    entra  = activo && (est_d != est_q);
    fase_d = fase_q;
    pat_d  = pat_q;
    if (est_q == GRAVE) lim = fase_q ? G_ON_L : G_OFF_L;
    else                lim = fase_q ? L_ON_L : L_OFF_L;
    if (!activo || entra) begin
      fase_d = 1'b1;
      pat_d  = '0;
    end else if (tick) begin
      if (pat_q == lim) begin
        fase_d = !fase_q;
        pat_d  = '0;
      end else begin
        pat_d = pat_q + PW'(1);
      end
    end
    buz_d = activo && fase_d;
    led_d = i_s || ((est_d == GRAVE) && fase_d);
  end

  // Motor starts on request and holds for the minimum on-time.
  always_comb begin
    mot_d  = mot_q;
    vent_d = vent_q;
    if (v_s && !mot_q) begin
      mot_d  = 1'b1;
      vent_d = VENT_LD;
    end else begin
      if (tick && vent_q != '0) vent_d = vent_q - VW'(1);
      if (!v_s && vent_q == '0) mot_d = 1'b0;
    end
  end

  // Synchronizers, state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      est_q  <= REPOSO;
      fase_q <= 1'b0;
      pat_q  <= '0;
      sil_q  <= '0;
      vent_q <= '0;
      mot_q  <= 1'b0;
      buz_q  <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      s1_q   <= {alarm_grave, alarm_leve,
                 ventilacion, iluminacion};
      s2_q   <= s1_q;
      est_q  <= est_d;
      fase_q <= fase_d;
      pat_q  <= pat_d;
      sil_q  <= sil_d;
      vent_q <= vent_d;
      mot_q  <= mot_d;
      buz_q  <= buz_d;
      led_q  <= led_d;
    end
  end

  assign buzzer     = buz_q;
  assign led_alerta = led_q;
  assign vent_motor = mot_q;
  assign estado     = est_q;

endmodule
